// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline-register bundle: ID-side operands in, EX-side copies out.
// The master drives the ID side; the slave is the register itself.
interface id_ex_reg_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [9:0]      id_ctrl;
    logic [1:0]      id_aluop;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [3:0]      id_funct;
    logic            flush;

    logic            ex_valid;
    logic [9:0]      ex_ctrl;
    logic [1:0]      ex_aluop;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic [RA_W-1:0] ex_rd;
    logic [3:0]      ex_funct;
    logic            stall_out;
    logic            halted;

    modport master (
        output id_valid, id_ctrl, id_aluop, id_pc, id_rs1_data,
        output id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct, flush,
        input  ex_valid, ex_ctrl, ex_aluop, ex_pc, ex_rs1_data,
        input  ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
        input  stall_out, halted
    );

    modport slave (
        input  id_valid, id_ctrl, id_aluop, id_pc, id_rs1_data,
        input  id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct, flush,
        output ex_valid, ex_ctrl, ex_aluop, ex_pc, ex_rs1_data,
        output ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
        output stall_out, halted
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall detection and flush.
// Define HALT_LATCH_EN for a sticky halt on a loaded EXIT instruction.
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic         clk,
    input logic         rst,
    id_ex_reg_if.slave  bus
);
    logic            valid_q, valid_d;
    logic [9:0]      ctrl_q, ctrl_d;
    logic [1:0]      aluop_q, aluop_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [3:0]      funct_q, funct_d;
    logic            halted_q, halted_d;
    logic            stall;
    logic            load;

    // rs2 is compared for every instruction type; a spurious stall is safe
    assign stall = bus.id_valid & valid_q & ctrl_q[8]
                 & (rd_q != '0)
                 & ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2))
                 & ~bus.flush & ~halted_q;

    assign load = bus.id_valid & ~halted_q & ~bus.flush & ~stall;

    always_comb begin
        valid_d    = 1'b0;
        ctrl_d     = '0;
        aluop_d    = '0;
        rd_d       = '0;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        funct_d    = funct_q;
        if (load) begin
            valid_d    = 1'b1;
            ctrl_d     = bus.id_ctrl;
            aluop_d    = bus.id_aluop;
            rd_d       = bus.id_rd;
            pc_d       = bus.id_pc;
            rs1_data_d = bus.id_rs1_data;
            rs2_data_d = bus.id_rs2_data;
            imm_d      = bus.id_imm;
            rs1_d      = bus.id_rs1;
            rs2_d      = bus.id_rs2;
            funct_d    = bus.id_funct;
        end
`ifdef HALT_LATCH_EN
        halted_d = halted_q | (load & bus.id_ctrl[0]);
`else
        halted_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            aluop_q    <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            aluop_q    <= aluop_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_aluop    = aluop_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_funct    = funct_q;
    assign bus.stall_out   = stall;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg; builds with or without HALT_LATCH_EN.
module tb_id_ex_reg;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_reg #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          r;
        bit          v;
        logic [9:0]  c;
        logic [1:0]  a;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        bit          fl;
        bit          es;
        bit          ev;
        logic [9:0]  ec;
        logic [1:0]  ea;
        logic [4:0]  erd;
        logic [4:0]  ers1;
        logic [31:0] epc;
        bit          eh;
    } vec_t;

    vec_t tbl[$];

`ifdef HALT_LATCH_EN
    localparam bit HEN = 1'b1;
`else
    localparam bit HEN = 1'b0;
`endif

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dexp(input logic [31:0] epc,
                                         input logic [31:0] k);
        return (epc == 32'h0) ? 32'h0 : epc + k;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst              = v.r;
        bus.id_valid     = v.v;
        bus.id_ctrl      = v.c;
        bus.id_aluop     = v.a;
        bus.id_pc        = v.pc;
        bus.id_rs1_data  = v.pc + 32'd1;
        bus.id_rs2_data  = v.pc + 32'd2;
        bus.id_imm       = v.pc + 32'd3;
        bus.id_rs1       = v.rs1;
        bus.id_rs2       = v.rs2;
        bus.id_rd        = v.rd;
        bus.id_funct     = v.pc[5:2];
        bus.flush        = v.fl;
        #1;
        chk({tag, " stall_out"}, {31'b0, bus.stall_out}, {31'b0, v.es});
        @(posedge clk);
        #1;
        chk({tag, " ex_valid"}, {31'b0, bus.ex_valid}, {31'b0, v.ev});
        chk({tag, " ex_ctrl"}, {22'b0, bus.ex_ctrl}, {22'b0, v.ec});
        chk({tag, " ex_aluop"}, {30'b0, bus.ex_aluop}, {30'b0, v.ea});
        chk({tag, " ex_rd"}, {27'b0, bus.ex_rd}, {27'b0, v.erd});
        chk({tag, " ex_rs1"}, {27'b0, bus.ex_rs1}, {27'b0, v.ers1});
        chk({tag, " ex_pc"}, bus.ex_pc, v.epc);
        chk({tag, " ex_rs1_data"}, bus.ex_rs1_data, dexp(v.epc, 32'd1));
        chk({tag, " ex_rs2_data"}, bus.ex_rs2_data, dexp(v.epc, 32'd2));
        chk({tag, " ex_imm"}, bus.ex_imm, dexp(v.epc, 32'd3));
        chk({tag, " ex_funct"}, {28'b0, bus.ex_funct}, {28'b0, v.epc[5:2]});
        chk({tag, " halted"}, {31'b0, bus.halted}, {31'b0, v.eh});
    endtask

    localparam logic [9:0] RT = 10'h010;
    localparam logic [9:0] LW = 10'h1B0;
    localparam logic [9:0] EC = 10'h001;

    initial begin
        rst             = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_ctrl     = '0;
        bus.id_aluop    = '0;
        bus.id_pc       = '0;
        bus.id_rs1_data = '0;
        bus.id_rs2_data = '0;
        bus.id_imm      = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_funct    = '0;
        bus.flush       = 1'b0;
        @(posedge clk);

        // reset with a fully-asserted control word
        add('{0,1,10'h3FF,3,32'hDEAD,7,7,7,0, 0,0,0,0,0,0,32'h0,0});
        // R-type pass-through
        add('{1,1,RT,2,32'h100,1,2,5,0, 0,1,RT,2,5,1,32'h100,0});
        // lw x5, then dependent add: one stall cycle
        add('{1,1,LW,0,32'h104,2,0,5,0, 0,1,LW,0,5,2,32'h104,0});
        add('{1,1,RT,2,32'h108,5,3,6,0, 1,0,0,0,0,2,32'h104,0});
        add('{1,1,RT,2,32'h108,5,3,6,0, 0,1,RT,2,6,5,32'h108,0});
        // lw x0 never stalls
        add('{1,1,LW,0,32'h10C,1,0,0,0, 0,1,LW,0,0,1,32'h10C,0});
        add('{1,1,RT,2,32'h110,0,0,7,0, 0,1,RT,2,7,0,32'h110,0});
        // back-to-back dependent loads, then rs2 dependence
        add('{1,1,LW,0,32'h114,1,0,8,0, 0,1,LW,0,8,1,32'h114,0});
        add('{1,1,LW,0,32'h118,8,0,9,0, 1,0,0,0,0,1,32'h114,0});
        add('{1,1,LW,0,32'h118,8,0,9,0, 0,1,LW,0,9,8,32'h118,0});
        add('{1,1,RT,2,32'h11C,3,9,10,0, 1,0,0,0,0,8,32'h118,0});
        add('{1,1,RT,2,32'h11C,3,9,10,0, 0,1,RT,2,10,3,32'h11C,0});
        // flush beats a load-use hazard
        add('{1,1,LW,0,32'h120,0,0,11,0, 0,1,LW,0,11,0,32'h120,0});
        add('{1,1,RT,2,32'h124,11,0,12,1, 0,0,0,0,0,0,32'h120,0});
        // invalid ID is a bubble whatever the control bits say
        add('{1,0,10'h3FF,3,32'h128,4,4,13,0, 0,0,0,0,0,0,32'h120,0});
        // ECALL
        add('{1,1,EC,0,32'h12C,0,0,0,0, 0,1,EC,0,0,0,32'h12C,HEN});
        if (HEN) begin
            add('{1,1,RT,2,32'h130,1,0,14,0, 0,0,0,0,0,0,32'h12C,1});
            add('{1,1,LW,0,32'h134,2,0,15,0, 0,0,0,0,0,0,32'h12C,1});
            add('{1,1,RT,2,32'h138,15,0,16,1, 0,0,0,0,0,0,32'h12C,1});
            add('{1,1,LW,0,32'h13C,1,0,17,0, 0,0,0,0,0,0,32'h12C,1});
            add('{0,1,RT,2,32'h140,17,0,18,0, 0,0,0,0,0,0,32'h0,0});
        end else begin
            add('{1,1,RT,2,32'h130,1,0,14,0, 0,1,RT,2,14,1,32'h130,0});
            add('{1,1,LW,0,32'h134,2,0,15,0, 0,1,LW,0,15,2,32'h134,0});
            add('{1,1,RT,2,32'h138,15,0,16,1, 0,0,0,0,0,2,32'h134,0});
            add('{1,1,LW,0,32'h13C,1,0,17,0, 0,1,LW,0,17,1,32'h13C,0});
            // reset while the stall condition is live
            add('{0,1,RT,2,32'h140,17,0,18,0, 1,0,0,0,0,0,32'h0,0});
        end
        add('{1,1,RT,2,32'h140,17,0,18,0, 0,1,RT,2,18,17,32'h140,0});

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // reset together with flush and a live hazard, then normal load
        run_vec('{1,1,LW,0,32'h200,1,0,20,0, 0,1,LW,0,20,1,32'h200,0}, "s0");
        run_vec('{0,1,RT,2,32'h204,20,0,21,1, 0,0,0,0,0,0,32'h0,0}, "s1");
        run_vec('{1,1,RT,2,32'h204,20,0,21,0, 0,1,RT,2,21,20,32'h204,0}, "s2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
